// File: rtl/persiana_pkg.sv
// persiana_pkg: shared state/command types for the blind motor driver.
package persiana_pkg;
  typedef enum logic [2:0] {IDLE, RAMP, RUN, BRAKE, FAULT} state_e;
  typedef enum logic [1:0] {CMD_STOP = 2'b00, CMD_UP = 2'b01, CMD_DOWN = 2'b10} cmd_e;
  function automatic cmd_e decode(input logic sub, input logic baj);
    return (sub & ~baj) ? CMD_UP : (baj & ~sub) ? CMD_DOWN : CMD_STOP;
  endfunction
endpackage

// File: rtl/persiana_sync2.sv
// persiana_sync2: W-bit two-flop synchronizer with async active-high reset.
module persiana_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reseteo,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge reseteo)
    if (reseteo) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/persiana_motor_driver.sv
// persiana_motor_driver: H-bridge driver with soft-start PWM, dead-time and run watchdog.
module persiana_motor_driver
  import persiana_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MIN    = 64,
  parameter int RAMP_DIV    = 4,
  parameter int DEAD_CYCLES = 16,
  parameter int TO_W        = 24,
  parameter int TIMEOUT     = 12_000_000
) (
  input  logic                clk,
  input  logic                reseteo,
  input  logic                subir,
  input  logic                bajar,
  input  logic                fin_sup,
  input  logic                fin_inf,
  output logic                in_a,
  output logic                in_b,
  output logic                motor_on,
  output logic [PWM_BITS-1:0] duty,
  output logic                fault
);
  localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] DMAX  = '1;
  localparam logic [PWM_BITS-1:0] DMIN  = PWM_BITS'(DUTY_MIN);
  localparam logic [RW-1:0]       RLAST = RW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]       DLAST = DW'(DEAD_CYCLES - 1);
  localparam logic [TO_W-1:0]     WLAST = TO_W'(TIMEOUT - 1);

  logic [3:0] s;
  logic s_sub, s_baj, fs, fi;
  persiana_sync2 #(.W(4)) u_sync (
    .clk    (clk),
    .reseteo(reseteo),
    .d      ({fin_inf, fin_sup, bajar, subir}),
    .q      (s)
  );
  assign {fi, fs, s_baj, s_sub} = s;

  cmd_e cmd, dir, dir_n;
  state_e st, st_n;
  logic [PWM_BITS-1:0] pc, pc_n, duty_n;
  logic [RW-1:0] rc, rc_n;
  logic [DW-1:0] dc, dc_n;
  logic [TO_W-1:0] wd, wd_n;
  logic go, hit, act_n, pwm_n;

  assign cmd  = decode(s_sub, s_baj);
  assign go   = (cmd == CMD_UP && !fs) || (cmd == CMD_DOWN && !fi);
  assign hit  = (cmd != dir) || (dir == CMD_UP && fs) || (dir == CMD_DOWN && fi);
  assign pc_n = pc + 1'b1;

  // Next-state decode; every register below loads from these so outputs track state on the same edge.
  always_comb begin
    st_n   = st;
    dir_n  = dir;
    duty_n = '0;
    rc_n   = '0;
    dc_n   = '0;
    wd_n   = '0;
    if (st != FAULT && fs && fi) st_n = FAULT;
    else
      case (st)
        IDLE: if (go) begin
          st_n   = RAMP;
          dir_n  = cmd;
          duty_n = DMIN;
        end
        RAMP, RUN:
          if (wd == WLAST) st_n = FAULT;
          else if (hit) st_n = BRAKE;
          else if (st == RUN) begin
            wd_n   = wd + 1'b1;
            duty_n = DMAX;
          end else begin
            wd_n   = wd + 1'b1;
            rc_n   = (rc == RLAST) ? '0 : rc + 1'b1;
            duty_n = (rc == RLAST && duty != DMAX) ? duty + 1'b1 : duty;
            st_n   = (duty_n == DMAX) ? RUN : RAMP;
          end
        BRAKE: begin
          dc_n = (dc == DLAST) ? '0 : dc + 1'b1;
          st_n = (dc == DLAST) ? IDLE : BRAKE;
        end
        FAULT: st_n = (cmd == CMD_STOP && !(fs && fi)) ? IDLE : FAULT;
        default: st_n = IDLE;
      endcase
  end

  assign act_n = (st_n == RAMP) || (st_n == RUN);
  assign pwm_n = pc_n < duty_n;

  always_ff @(posedge clk or posedge reseteo)
    if (reseteo) begin
      st       <= IDLE;
      dir      <= CMD_STOP;
      pc       <= '0;
      rc       <= '0;
      dc       <= '0;
      wd       <= '0;
      duty     <= '0;
      in_a     <= 1'b0;
      in_b     <= 1'b0;
      motor_on <= 1'b0;
      fault    <= 1'b0;
    end else begin
      st       <= st_n;
      dir      <= dir_n;
      pc       <= pc_n;
      rc       <= rc_n;
      dc       <= dc_n;
      wd       <= wd_n;
      duty     <= duty_n;
      in_a     <= act_n && pwm_n && dir_n == CMD_UP;
      in_b     <= act_n && pwm_n && dir_n == CMD_DOWN;
      motor_on <= act_n;
      fault    <= st_n == FAULT;
    end
endmodule

// File: tb/tb_persiana_motor_driver.sv
// tb_persiana_motor_driver: directed scoreboard bench for the blind motor driver.
module tb_persiana_motor_driver;
  logic clk = 1'b0, reseteo = 1'b1;
  logic subir = 1'b0, bajar = 1'b0, fin_sup = 1'b0, fin_inf = 1'b0;
  logic in_a, in_b, motor_on, fault;
  logic [7:0] duty;
  logic [7:0] pc_m;
  int checks = 0, errors = 0;

  typedef enum {O_MOTOR, O_DUTY, O_FAULT, O_A, O_B, O_APWM, O_BPWM} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  persiana_motor_driver #(
    .PWM_BITS(8), .DUTY_MIN(250), .RAMP_DIV(2), .DEAD_CYCLES(4), .TO_W(24), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reseteo(reseteo), .subir(subir), .bajar(bajar),
    .fin_sup(fin_sup), .fin_inf(fin_inf), .in_a(in_a), .in_b(in_b),
    .motor_on(motor_on), .duty(duty), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference PWM counter: free-running from reset release.
  always @(posedge clk or posedge reseteo) pc_m <= reseteo ? 8'd0 : pc_m + 8'd1;

  always @(negedge clk) begin
    checks++;
    assert ((in_a & in_b) === 1'b0) else begin
      errors++;
      $error("FAIL excl observed=%b expected=0", in_a & in_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp(input string tag, input sel_e s, input int v);
    q.push_back('{tag, s, 32'(v)});
  endtask

  task automatic chk;
    exp_t e;
    logic [31:0] obs, ex;
    while (q.size() > 0) begin
      e  = q.pop_front();
      ex = e.val;
      case (e.sel)
        O_MOTOR: obs = {31'b0, motor_on};
        O_DUTY:  obs = {24'b0, duty};
        O_FAULT: obs = {31'b0, fault};
        O_A:     obs = {31'b0, in_a};
        O_B:     obs = {31'b0, in_b};
        O_APWM: begin obs = {31'b0, in_a}; ex = {31'b0, pc_m < e.val[7:0]}; end
        default: begin obs = {31'b0, in_b}; ex = {31'b0, pc_m < e.val[7:0]}; end
      endcase
      checks++;
      assert (obs === ex) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, ex);
      end
    end
  endtask

  initial begin
    tick(3);
    exp("rst_motor", O_MOTOR, 0); exp("rst_duty", O_DUTY, 0); exp("rst_fault", O_FAULT, 0);
    exp("rst_a", O_A, 0); exp("rst_b", O_B, 0); chk();
    reseteo = 1'b0;
    // 1: soft-start up
    subir = 1'b1;
    tick(2); exp("t1_lat", O_MOTOR, 0); chk();
    tick(1); exp("t1_on", O_MOTOR, 1); exp("t1_dmin", O_DUTY, 250); exp("t1_b", O_B, 0);
    exp("t1_pwm", O_APWM, 250); chk();
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      exp("t1_ramp", O_DUTY, 250 + k / 2); exp("t1_on_r", O_MOTOR, 1);
      exp("t1_b_r", O_B, 0); exp("t1_pwm_r", O_APWM, 250 + k / 2); chk();
    end
    tick(1); exp("t1_run", O_DUTY, 255); exp("t1_run_pwm", O_APWM, 255); chk();
    // 2: top limit in RUN
    fin_sup = 1'b1;
    tick(2); exp("t2_pre", O_MOTOR, 1); exp("t2_pre_d", O_DUTY, 255); chk();
    tick(1); exp("t2_a", O_A, 0); exp("t2_duty", O_DUTY, 0); exp("t2_motor", O_MOTOR, 0); chk();
    tick(8); exp("t2_norestart", O_MOTOR, 0); exp("t2_d", O_DUTY, 0); exp("t2_a2", O_A, 0); chk();
    subir = 1'b0; fin_sup = 1'b0;
    tick(4);
    // 3: reversal with dead-time
    subir = 1'b1;
    tick(3); exp("t3_on", O_MOTOR, 1); exp("t3_dmin", O_DUTY, 250); chk();
    tick(12); exp("t3_run", O_DUTY, 255); chk();
    subir = 1'b0; bajar = 1'b1;
    tick(2); exp("t3_pre", O_MOTOR, 1); chk();
    tick(1); exp("t3_brk", O_MOTOR, 0); exp("t3_a", O_A, 0); exp("t3_b", O_B, 0); exp("t3_d", O_DUTY, 0); chk();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      exp("t3_dead", O_MOTOR, 0); exp("t3_dead_a", O_A, 0); exp("t3_dead_b", O_B, 0);
      exp("t3_dead_d", O_DUTY, 0); chk();
    end
    tick(1); exp("t3_down", O_MOTOR, 1); exp("t3_down_d", O_DUTY, 250); exp("t3_down_a", O_A, 0);
    exp("t3_down_pwm", O_BPWM, 250); chk();
    bajar = 1'b0;
    tick(10); exp("t3_stop", O_MOTOR, 0); chk();
    // 4: watchdog
    subir = 1'b1;
    tick(3); exp("t4_on", O_MOTOR, 1); chk();
    tick(99); exp("t4_pre", O_MOTOR, 1); exp("t4_pre_f", O_FAULT, 0); chk();
    tick(1); exp("t4_fault", O_FAULT, 1); exp("t4_off", O_MOTOR, 0); exp("t4_a", O_A, 0);
    exp("t4_d", O_DUTY, 0); chk();
    tick(5); exp("t4_hold", O_FAULT, 1); chk();
    subir = 1'b0;
    tick(2); exp("t4_lat", O_FAULT, 1); chk();
    tick(1); exp("t4_clr", O_FAULT, 0); exp("t4_idle", O_MOTOR, 0); chk();
    // 5: sensor fault
    tick(2);
    subir = 1'b1;
    tick(15); exp("t5_run", O_MOTOR, 1); exp("t5_run_d", O_DUTY, 255); chk();
    fin_sup = 1'b1; fin_inf = 1'b1;
    tick(2); exp("t5_pre", O_FAULT, 0); exp("t5_pre_m", O_MOTOR, 1); chk();
    tick(1); exp("t5_fault", O_FAULT, 1); exp("t5_off", O_MOTOR, 0); exp("t5_a", O_A, 0); chk();
    subir = 1'b0;
    tick(6); exp("t5_stuck", O_FAULT, 1); chk();
    fin_inf = 1'b0;
    tick(2); exp("t5_lat", O_FAULT, 1); chk();
    tick(1); exp("t5_clr", O_FAULT, 0); chk();
    fin_sup = 1'b0;
    tick(3);
    // 6: async reset mid-ramp
    subir = 1'b1;
    tick(5); exp("t6_ramp", O_DUTY, 251); exp("t6_on", O_MOTOR, 1); chk();
    #2 reseteo = 1'b1;
    #1;
    exp("t6_rst_m", O_MOTOR, 0); exp("t6_rst_d", O_DUTY, 0); exp("t6_rst_a", O_A, 0);
    exp("t6_rst_b", O_B, 0); exp("t6_rst_f", O_FAULT, 0); chk();
    tick(2);
    reseteo = 1'b0;
    tick(2); exp("t6_lat", O_MOTOR, 0); chk();
    tick(1); exp("t6_on2", O_MOTOR, 1); exp("t6_dmin", O_DUTY, 250); exp("t6_pwm", O_APWM, 250); chk();
    tick(2); exp("t6_step", O_DUTY, 251); chk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
